// File: rtl/nvi_int_pkg.sv
// nvi_int_pkg: shared constants and types for the MCS-51 interrupt controller.
//   - source index enum in fixed arbitration order
//   - SFR addresses and implemented-bit masks for IE / IP
//   - FSM state enum and the vector address helper
package nvi_int_pkg;

  typedef enum logic [2:0] {
    SRC_EX0   = 3'd0,
    SRC_TF0   = 3'd1,
    SRC_EX1   = 3'd2,
    SRC_TF1   = 3'd3,
    SRC_UART0 = 3'd4
  } src_e;

  localparam logic [7:0]  SFR_IE     = 8'hA8;
  localparam logic [7:0]  SFR_IP     = 8'hB8;
  // IE keeps EA plus the five enables; IP keeps the five priority bits.
  localparam logic [7:0]  IE_MASK    = 8'h9F;
  localparam logic [7:0]  IP_MASK    = 8'h1F;
  localparam logic [15:0] VEC_STRIDE = 16'h0008;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  // Vector = base + 8 * idx.
  function automatic logic [15:0] vec_of(input logic [15:0] base, input logic [2:0] idx);
    return base + {10'b0, idx, 3'b000};
  endfunction

endpackage

// File: rtl/nvi_int_prio_enc.sv
// nvi_int_prio_enc: combinational two-level priority encoder.
//   elig_i  [4:0] eligible sources (pending, enabled, EA set)
//   ip_i    [4:0] priority bits, 1 = high level
//   valid_o       some source is eligible
//   idx_o   [2:0] winning source index
//   level_o       winning level (1 = high)
// High level beats low; within a level the lowest index wins.
module nvi_int_prio_enc (
  input  logic [4:0] elig_i,
  input  logic [4:0] ip_i,
  output logic       valid_o,
  output logic [2:0] idx_o,
  output logic       level_o
);

  logic [4:0] hi;
  logic [4:0] lo;

  always_comb begin
    hi      = elig_i & ip_i;
    lo      = elig_i & ~ip_i;
    valid_o = |elig_i;
    level_o = |hi;
    idx_o   = 3'd0;
    // Scan downward so the lowest set index is the last assignment.
    if (|hi) begin
      for (int i = 4; i >= 0; i--) begin
        if (hi[i]) idx_o = 3'(i);
      end
    end else begin
      for (int i = 4; i >= 0; i--) begin
        if (lo[i]) idx_o = 3'(i);
      end
    end
  end

endmodule

// File: rtl/nvi_int_ctrl.sv
// nvi_int_ctrl: MCS-51 interrupt controller.
//   clk, reset_n                 core clock, async active-low reset
//   mem_*                        Naive-Memory Interface (IE at A8, IP at B8)
//   int_exIO0..int_UART0         level requests from the peripheral block
//   int_resp_n[7:0]              active-low one-cycle acknowledge per source
//   int_req / int_vector         request and LCALL target to the CPU
//   int_ack / int_reti           CPU vector accept and RETI pulses
// Holds IE/IP, the sampled pending bits, two-level in-service state, the
// one-cycle blackout flag and the IDLE/REQ request FSM.
module nvi_int_ctrl
  import nvi_int_pkg::*;
#(
  parameter int          N_SRC    = 5,
  parameter logic [15:0] VEC_BASE = 16'h0003
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_sel,
  input  logic        mem_we_n,
  input  logic        mem_rd_n,
  input  logic        mem_sfr_n,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        mem_ready_out,
  input  logic        int_exIO0,
  input  logic        int_TF0,
  input  logic        int_exIO1,
  input  logic        int_TF1,
  input  logic        int_UART0,
  output logic [7:0]  int_resp_n,
  output logic        int_req,
  output logic [15:0] int_vector,
  input  logic        int_ack,
  input  logic        int_reti
);

  logic [7:0]       ie_q, ip_q;
  logic [N_SRC-1:0] pend_q;
  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             lvl_q, lvl_d;
  logic [15:0]      vec_q, vec_d;
  logic             insvc_hi_q, insvc_hi_d;
  logic             insvc_lo_q, insvc_lo_d;
  logic             blk_q, blk_d;
  logic [7:0]       resp_q, resp_d;

  logic             sfr_wr, sfr_rd, ie_wr, ip_wr;
  logic [4:0]       elig;
  logic [7:0]       elig8;
  logic             enc_valid, enc_level, req_ok;
  logic [2:0]       enc_idx;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^mem_addr[15:8];

  assign sfr_wr = mem_sel & ~mem_sfr_n & ~mem_we_n;
  assign sfr_rd = mem_sel & ~mem_sfr_n & ~mem_rd_n;
  assign ie_wr  = sfr_wr & (mem_addr[7:0] == SFR_IE);
  assign ip_wr  = sfr_wr & (mem_addr[7:0] == SFR_IP);

  always_comb begin
    mem_rdata = 8'h00;
    if (sfr_rd) begin
      if (mem_addr[7:0] == SFR_IE)      mem_rdata = ie_q;
      else if (mem_addr[7:0] == SFR_IP) mem_rdata = ip_q;
    end
  end
  assign mem_ready_out = 1'b1;

  assign elig  = pend_q & ie_q[4:0] & {5{ie_q[7]}};
  assign elig8 = {3'b000, elig};

  nvi_int_prio_enc u_prio_enc (
    .elig_i  (elig),
    .ip_i    (ip_q[4:0]),
    .valid_o (enc_valid),
    .idx_o   (enc_idx),
    .level_o (enc_level)
  );

  // A high-level service blocks everything; a low-level service blocks only low.
  assign req_ok = enc_valid & ~insvc_hi_q & (enc_level | ~insvc_lo_q);

  // A register write or RETI lets one more instruction run before vectoring.
  assign blk_d = int_reti | ie_wr | ip_wr;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lvl_d   = lvl_q;
    vec_d   = vec_q;
    resp_d  = 8'hFF;
    // RETI retires the innermost level first; a same-cycle ack lands after it.
    insvc_hi_d = insvc_hi_q & ~int_reti;
    insvc_lo_d = insvc_lo_q & ~(int_reti & ~insvc_hi_q);
    case (state_q)
      ST_IDLE: begin
        if (req_ok && !blk_q) begin
          state_d = ST_REQ;
          idx_d   = enc_idx;
          lvl_d   = enc_level;
          vec_d   = vec_of(VEC_BASE, enc_idx);
        end
      end
      ST_REQ: begin
        if (int_ack) begin
          state_d = ST_IDLE;
          if (lvl_q) insvc_hi_d = 1'b1;
          else       insvc_lo_d = 1'b1;
          resp_d[idx_q] = 1'b0;
        end else if (!elig8[idx_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ie_q       <= 8'h00;
      ip_q       <= 8'h00;
      pend_q     <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      lvl_q      <= 1'b0;
      vec_q      <= 16'h0000;
      insvc_hi_q <= 1'b0;
      insvc_lo_q <= 1'b0;
      blk_q      <= 1'b0;
      resp_q     <= 8'hFF;
    end else begin
      if (ie_wr) ie_q <= mem_wdata & IE_MASK;
      if (ip_wr) ip_q <= mem_wdata & IP_MASK;
      pend_q     <= N_SRC'({int_UART0, int_TF1, int_exIO1, int_TF0, int_exIO0});
      state_q    <= state_d;
      idx_q      <= idx_d;
      lvl_q      <= lvl_d;
      vec_q      <= vec_d;
      insvc_hi_q <= insvc_hi_d;
      insvc_lo_q <= insvc_lo_d;
      blk_q      <= blk_d;
      resp_q     <= resp_d;
    end
  end

  assign int_req    = (state_q == ST_REQ);
  assign int_vector = vec_q;
  assign int_resp_n = resp_q;

endmodule

// File: tb/tb_nvi_int_ctrl.sv
module tb_nvi_int_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        mem_sel, mem_we_n, mem_rd_n, mem_sfr_n;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ready_out;
  logic        int_exIO0, int_TF0, int_exIO1, int_TF1, int_UART0;
  logic [7:0]  int_resp_n;
  logic        int_req;
  logic [15:0] int_vector;
  logic        int_ack, int_reti;

  always #5 clk = ~clk;

  nvi_int_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .mem_sel       (mem_sel),
    .mem_we_n      (mem_we_n),
    .mem_rd_n      (mem_rd_n),
    .mem_sfr_n     (mem_sfr_n),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ready_out (mem_ready_out),
    .int_exIO0     (int_exIO0),
    .int_TF0       (int_TF0),
    .int_exIO1     (int_exIO1),
    .int_TF1       (int_TF1),
    .int_UART0     (int_UART0),
    .int_resp_n    (int_resp_n),
    .int_req       (int_req),
    .int_vector    (int_vector),
    .int_ack       (int_ack),
    .int_reti      (int_reti)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        req;
    logic [15:0] vec;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       sfr_n;
    logic [7:0] rd_ie;
    logic [7:0] rd_ip;
  } sfr_vec_t;

  typedef struct {
    logic [7:0]  ie;
    logic [7:0]  ip;
    logic [4:0]  src;
    logic        req;
    logic [15:0] vec;
  } arb_vec_t;

  sfr_vec_t sfr_tbl[6];
  arb_vec_t arb_tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_src(input logic [4:0] s);
    {int_UART0, int_TF1, int_exIO1, int_TF0, int_exIO0} = s;
  endtask

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d, input logic sfr_n = 1'b0);
    mem_sel   = 1'b1;
    mem_sfr_n = sfr_n;
    mem_we_n  = 1'b0;
    mem_addr  = {8'h00, a};
    mem_wdata = d;
    tick();
    mem_sel   = 1'b0;
    mem_sfr_n = 1'b1;
    mem_we_n  = 1'b1;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d);
    mem_sel   = 1'b1;
    mem_sfr_n = 1'b0;
    mem_rd_n  = 1'b0;
    mem_addr  = {8'h00, a};
    #1;
    d = mem_rdata;
    mem_sel   = 1'b0;
    mem_sfr_n = 1'b1;
    mem_rd_n  = 1'b1;
  endtask

  // Push the expectation now, let n cycles elapse, then pop and compare.
  task automatic expect_req(input string name, input int n, input logic req, input logic [15:0] vec);
    exp_t e;
    sbq.push_back('{req, vec});
    tick(n);
    e = sbq.pop_front();
    check({name, "_req"}, 32'(int_req), 32'(e.req));
    if (e.req) check({name, "_vec"}, 32'(int_vector), 32'(e.vec));
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic pulse_reti();
    int_reti = 1'b1;
    tick();
    int_reti = 1'b0;
  endtask

  task automatic do_reset();
    set_src(5'b0);
    int_ack  = 1'b0;
    int_reti = 1'b0;
    reset_n  = 1'b0;
    tick();
    reset_n  = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;

    sfr_tbl[0] = '{8'hA8, 8'hFF, 1'b0, 8'h9F, 8'h00};
    sfr_tbl[1] = '{8'hB8, 8'hFF, 1'b0, 8'h9F, 8'h1F};
    sfr_tbl[2] = '{8'hA8, 8'h60, 1'b0, 8'h00, 8'h1F};
    sfr_tbl[3] = '{8'hB8, 8'hE0, 1'b0, 8'h00, 8'h00};
    sfr_tbl[4] = '{8'hA8, 8'h85, 1'b1, 8'h00, 8'h00};
    sfr_tbl[5] = '{8'h90, 8'hFF, 1'b0, 8'h00, 8'h00};

    arb_tbl[0] = '{8'h82, 8'h00, 5'b00010, 1'b1, 16'h000B};
    arb_tbl[1] = '{8'h9F, 8'h00, 5'b10100, 1'b1, 16'h0013};
    arb_tbl[2] = '{8'h9F, 8'h10, 5'b10101, 1'b1, 16'h0023};
    arb_tbl[3] = '{8'h9F, 8'h00, 5'b11111, 1'b1, 16'h0003};
    arb_tbl[4] = '{8'h1F, 8'h00, 5'b11111, 1'b0, 16'h0000};
    arb_tbl[5] = '{8'h88, 8'h00, 5'b00111, 1'b0, 16'h0000};
    arb_tbl[6] = '{8'h8C, 8'h04, 5'b01100, 1'b1, 16'h0013};
    arb_tbl[7] = '{8'h9F, 8'h1F, 5'b11000, 1'b1, 16'h001B};
    arb_tbl[8] = '{8'h8A, 8'h02, 5'b01010, 1'b1, 16'h000B};

    mem_sel = 1'b0; mem_we_n = 1'b1; mem_rd_n = 1'b1; mem_sfr_n = 1'b1;
    mem_addr = 16'h0000; mem_wdata = 8'h00;
    set_src(5'b0);
    int_ack = 1'b0; int_reti = 1'b0;
    reset_n = 1'b0;
    tick(2);

    // Reset state
    check("rst_req", 32'(int_req), 32'h0);
    check("rst_vec", 32'(int_vector), 32'h0000);
    check("rst_resp", 32'(int_resp_n), 32'hFF);
    check("ready", 32'(mem_ready_out), 32'h1);
    sfr_read(8'hA8, rd);
    check("rst_ie", 32'(rd), 32'h00);
    reset_n = 1'b1;
    tick();

    // SFR write/read table
    for (int i = 0; i < 6; i++) begin
      sfr_write(sfr_tbl[i].addr, sfr_tbl[i].wdata, sfr_tbl[i].sfr_n);
      sfr_read(8'hA8, rd);
      check($sformatf("sfr%0d_ie", i), 32'(rd), 32'(sfr_tbl[i].rd_ie));
      sfr_read(8'hB8, rd);
      check($sformatf("sfr%0d_ip", i), 32'(rd), 32'(sfr_tbl[i].rd_ip));
    end
    sfr_write(8'hA8, 8'h9F);
    sfr_read(8'h90, rd);
    check("rd_other", 32'(rd), 32'h00);
    tick();

    // Arbitration table: exact two-cycle latency, winner vector, withdrawal
    for (int i = 0; i < 9; i++) begin
      sfr_write(8'hA8, arb_tbl[i].ie);
      sfr_write(8'hB8, arb_tbl[i].ip);
      tick();
      set_src(arb_tbl[i].src);
      expect_req($sformatf("arb%0d_lat", i), 1, 1'b0, 16'h0000);
      expect_req($sformatf("arb%0d", i), 1, arb_tbl[i].req, arb_tbl[i].vec);
      set_src(5'b0);
      tick(3);
      check($sformatf("arb%0d_wd", i), 32'(int_req), 32'h0);
      check($sformatf("arb%0d_resp", i), 32'(int_resp_n), 32'hFF);
    end

    // Single source with ack and RETI
    do_reset();
    sfr_write(8'hA8, 8'h82);
    tick();
    set_src(5'b00010);
    expect_req("single", 2, 1'b1, 16'h000B);
    pulse_ack();
    check("single_ack_req", 32'(int_req), 32'h0);
    check("single_resp", 32'(int_resp_n), 32'hFD);
    tick();
    check("single_resp_end", 32'(int_resp_n), 32'hFF);
    tick(3);
    check("single_insvc_block", 32'(int_req), 32'h0);
    pulse_reti();
    check("single_reti0", 32'(int_req), 32'h0);
    expect_req("single_reti1", 1, 1'b0, 16'h0000);
    expect_req("single_reti2", 1, 1'b1, 16'h000B);

    // Same-level priority, then next source after RETI
    do_reset();
    sfr_write(8'hA8, 8'h9F);
    sfr_write(8'hB8, 8'h00);
    tick();
    set_src(5'b10100);
    expect_req("same", 2, 1'b1, 16'h0013);
    pulse_ack();
    check("same_resp", 32'(int_resp_n), 32'hFB);
    set_src(5'b10000);
    tick(3);
    check("same_block", 32'(int_req), 32'h0);
    pulse_reti();
    expect_req("same_reti1", 1, 1'b0, 16'h0000);
    expect_req("same_reti2", 1, 1'b1, 16'h0023);

    // Nesting: high-level TF1 preempts low-level TF0
    do_reset();
    sfr_write(8'hA8, 8'h8A);
    sfr_write(8'hB8, 8'h08);
    tick();
    set_src(5'b00010);
    expect_req("nest_tf0", 2, 1'b1, 16'h000B);
    pulse_ack();
    set_src(5'b01000);
    expect_req("nest_tf1", 2, 1'b1, 16'h001B);
    pulse_ack();
    check("nest_resp", 32'(int_resp_n), 32'hF7);
    set_src(5'b00010);
    tick(3);
    check("nest_block2", 32'(int_req), 32'h0);
    pulse_reti();
    tick(3);
    check("nest_block1", 32'(int_req), 32'h0);
    pulse_reti();
    expect_req("nest_reti2a", 1, 1'b0, 16'h0000);
    expect_req("nest_reti2b", 1, 1'b1, 16'h000B);

    // Withdrawal by IE write, then blackout after re-enable
    do_reset();
    sfr_write(8'hA8, 8'h81);
    tick();
    set_src(5'b00001);
    expect_req("wd", 2, 1'b1, 16'h0003);
    sfr_write(8'hA8, 8'h00);
    tick();
    check("wd_drop", 32'(int_req), 32'h0);
    check("wd_noresp", 32'(int_resp_n), 32'hFF);
    tick();
    check("wd_noresp2", 32'(int_resp_n), 32'hFF);
    sfr_write(8'hA8, 8'h81);
    check("blk_w0", 32'(int_req), 32'h0);
    expect_req("blk_w1", 1, 1'b0, 16'h0000);
    expect_req("blk_w2", 1, 1'b1, 16'h0003);

    // Simultaneous ack and RETI
    do_reset();
    sfr_write(8'hA8, 8'h8A);
    sfr_write(8'hB8, 8'h08);
    tick();
    set_src(5'b00010);
    expect_req("sim_tf0", 2, 1'b1, 16'h000B);
    pulse_ack();
    set_src(5'b01000);
    expect_req("sim_tf1", 2, 1'b1, 16'h001B);
    int_ack  = 1'b1;
    int_reti = 1'b1;
    tick();
    int_ack  = 1'b0;
    int_reti = 1'b0;
    check("sim_req", 32'(int_req), 32'h0);
    check("sim_resp", 32'(int_resp_n), 32'hF7);
    set_src(5'b01010);
    tick(3);
    check("sim_hi_block", 32'(int_req), 32'h0);
    pulse_reti();
    expect_req("sim_reti1", 1, 1'b0, 16'h0000);
    expect_req("sim_reti2", 1, 1'b1, 16'h001B);

    // Asynchronous reset while a request is outstanding
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_req", 32'(int_req), 32'h0);
    check("arst_vec", 32'(int_vector), 32'h0000);
    check("arst_resp", 32'(int_resp_n), 32'hFF);
    sfr_read(8'hA8, rd);
    check("arst_ie", 32'(rd), 32'h00);
    sfr_read(8'hB8, rd);
    check("arst_ip", 32'(rd), 32'h00);
    set_src(5'b0);
    tick();
    reset_n = 1'b1;
    tick(2);
    check("post_rst_req", 32'(int_req), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nvi_int_ctrl.md
# nvi_int_ctrl

Interrupt controller for the MCS-51 core: it arbitrates the five peripheral interrupt sources (exIO0, TF0, exIO1, TF1, UART0) and schedules CPU vectoring between them. It sits between `nvi_periDev` and the CPU sequencer. It owns the IE (0xA8) and IP (0xB8) SFRs on the Naive-Memory Interface, tracks two-level in-service nesting, and returns the active-low per-source response pulses (`int_resp_n`) that clear edge-triggered flags in the peripheral.

## Interface
- `N_SRC`, 5, number of interrupt sources (fixed order: exIO0, TF0, exIO1, TF1, UART0)
- `VEC_BASE`, 16'h0003, vector of source 0; stride is 8
- `clk`  in  1  core clock
- `reset_n`  in  1  asynchronous, active-low reset (one clock domain; polarity and synchronicity fixed)
- `mem_sel, mem_we_n, mem_rd_n, mem_sfr_n`  in  1 each  Naive-Memory Interface strobes
- `mem_addr`  in  16  address; bits [7:0] decoded when `mem_sfr_n`=0
- `mem_wdata`  in  8  write data
- `mem_rdata`  out  8  read data
- `mem_ready_out`  out  1  access ready
- `int_exIO0, int_TF0, int_exIO1, int_TF1, int_UART0`  in  1 each  level requests from peripheral
- `int_resp_n`  out  8  active-low one-cycle acknowledge per source; bits [7:5] tied 1
- `int_req`  out  1  interrupt request to CPU
- `int_vector`  out  16  LCALL target, valid while `int_req`=1
- `int_ack`  in  1  CPU accepts vector (one-cycle pulse)
- `int_reti`  in  1  CPU executed RETI (one-cycle pulse)

## Operation
- **SFRs.** IE = {EA, 2'b0, ES, ET1, EX1, ET0, EX0}; IP = {3'b0, PS, PT1, PX1, PT0, PX0}. Unimplemented bits are write-ignored and read as 0.
- **SFR writes** occur when `mem_sel & ~mem_sfr_n & ~mem_we_n` and addr[7:0] is A8/B8. Reads return the register; non-matching addresses return 8'h00. `mem_ready_out` is constant 1.
- **Sampling.** Each cycle, the source inputs are registered into `pend[4:0]`. Eligibility is `pend & IE[4:0] & {5{EA}}`.
- **Arbitration.** Among eligible sources, the high level (IP bit = 1) beats the low level. Within a level, the lowest index wins.
- **Preemption rule.** A winner at level L is requestable only if `insvc_hi`=0 and (L=high or `insvc_lo`=0).
- **FSM states:**
  - IDLE: a requestable winner exists and there is no blackout -> REQ. The winner index and level are latched, `int_vector` = VEC_BASE + 8·idx, and `int_req`=1.
  - REQ, `int_ack`=1: set `insvc_{level}`, drive `int_resp_n[idx]`=0 for exactly one cycle, -> IDLE.
  - REQ, `int_ack`=0 and the latched source is no longer eligible: drop `int_req` and go -> IDLE (request withdrawn).
  - REQ, otherwise: hold. The vector does not change even if a higher source arrives; re-arbitration happens only in IDLE.
- **RETI.** `int_reti` clears `insvc_hi` if it is set, else `insvc_lo`. With both clear it is a no-op.
- **Blackout.** No IDLE->REQ transition in the cycle after `int_reti`, or in the cycle after any IE/IP write. This models the 51 rule that one more instruction executes.
- **Simultaneous ack and reti.** RETI is applied first, then ack sets the new in-service bit.
- **Reset.** Asynchronous reset clears state anytime, including mid-REQ: IE=IP=8'h00, `insvc`=0, `pend`=0, FSM=IDLE, `int_req`=0, `int_vector`=16'h0000, `int_resp_n`=8'hFF, `mem_rdata`=8'h00.

## Timing
- A source rising at edge N is in `pend` after N+1. `int_req` is high after N+2, with `int_vector` valid in the same cycle.
- `int_ack` sampled at edge M drops `int_req` after M+1. `int_resp_n[idx]` is low for cycle M+1..M+2 only.
- Earliest next request after ack is 1 cycle later (IDLE re-arbitrates). After reti, it is 2 cycles later.
- SFR write at edge W: the new IE/IP is visible to read and arbitration after W+1. Arbitration is blocked for that cycle.
- `mem_rdata` is combinational from the registers and strobes, with zero wait states.

## Structure
- **Package `nvi_int_pkg`:** source-index enum (`SRC_EX0..SRC_UART0`), `SFR_IE`=8'hA8, `SFR_IP`=8'hB8, vector constants, FSM state enum `{ST_IDLE, ST_REQ}`.
- **Sub-module `nvi_int_prio_enc`:** combinational two-level priority encoder. Inputs are eligible[4:0] and IP[4:0]. Outputs are valid, idx[2:0] and level.
- **Top:** holds the registers, FSM, in-service bits and blackout flag.

## Test plan
- **Single source.** IE=8'h82, `int_TF0`=1 -> `int_req` two cycles later with vector 16'h000B. `int_ack` -> `int_resp_n`=8'hFD for one cycle, `insvc_lo`=1.
- **Same-level priority.** IE=8'h9F, IP=0, exIO1 and UART0 high together -> vector 16'h0013. After ack, no further request until `int_reti`. Then UART0 -> 16'h0023, issued 2 cycles after reti.
- **Nesting.** IE=8'h8A, IP=8'h08, TF0 in service at low level, then TF1 asserted -> preempts with 16'h001B. A second TF0 is blocked until two RETIs.
- **Withdrawal and blackout.** During REQ for EX0, write IE=8'h00 -> `int_req` drops with no `int_resp_n` pulse. Rewrite IE=8'h81 -> no request in the blackout cycle, then request 16'h0003.
- **Simultaneous ack and reti.** With `insvc_lo`=1 and a pending high-level TF1 request, pulse `int_ack` and `int_reti` together -> `insvc_lo`=0 and `insvc_hi`=1.
- **Reset mid-REQ.** Assert `reset_n`=0 while `int_req`=1 -> all outputs at reset values immediately. IE/IP read back 8'h00.
